// File: rtl/tessia_alu_pkg.sv
// Shared opcode, flag-index and sequencer-state definitions for the tessia ALU cluster.
package tessia_alu_pkg;

  localparam int unsigned CTRL_W = 4;
  localparam int unsigned FLG_W  = 4;

  localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_MUL = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_MOD = 4'b0100;
  localparam logic [CTRL_W-1:0] ALU_AND = 4'b0101;
  localparam logic [CTRL_W-1:0] ALU_CPY = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_DIV = 4'b0111;

  localparam int unsigned FLG_NEG   = 3;
  localparam int unsigned FLG_ZERO  = 2;
  localparam int unsigned FLG_CARRY = 1;
  localparam int unsigned FLG_OVF   = 0;

  // Accumulator seed: OR-reduced flags start at 0, the AND-reduced zero flag at 1.
  localparam logic [FLG_W-1:0] FLAGS_INIT = 4'b0100;
  localparam logic [FLG_W-1:0] FLAGS_DZ   = 4'b0100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } seq_state_t;

  function automatic logic is_div_op(input logic [CTRL_W-1:0] ctrl);
    return (ctrl == ALU_MOD) || (ctrl == ALU_DIV);
  endfunction

endpackage

// File: rtl/alu_vector_sequencer_if.sv
// Start/done handshake and shared-ALU bus of the vector sequencer.
interface alu_vector_sequencer_if
  import tessia_alu_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned LANES = 4
);
  logic                 start_valid;
  logic                 start_ready;
  logic [CTRL_W-1:0]    op_ctrl;
  logic [LANES*N-1:0]   vec_a;
  logic [LANES*N-1:0]   vec_b;
  logic [N-1:0]         alu_a;
  logic [N-1:0]         alu_b;
  logic [CTRL_W-1:0]    alu_ctrl;
  logic [N-1:0]         alu_result;
  logic [FLG_W-1:0]     alu_flags;
  logic                 done_valid;
  logic                 done_ready;
  logic [LANES*N-1:0]   vec_result;
  logic [FLG_W-1:0]     vec_flags;
  logic                 div_zero;

  // Environment side: issues ops, hosts the ALU, consumes results.
  modport master (
    output start_valid, op_ctrl, vec_a, vec_b, alu_result, alu_flags, done_ready,
    input  start_ready, alu_a, alu_b, alu_ctrl, done_valid, vec_result, vec_flags, div_zero
  );

  // Sequencer side.
  modport slave (
    input  start_valid, op_ctrl, vec_a, vec_b, alu_result, alu_flags, done_ready,
    output start_ready, alu_a, alu_b, alu_ctrl, done_valid, vec_result, vec_flags, div_zero
  );
endinterface

// File: rtl/alu_flag_reducer.sv
// Per-lane flag accumulation: OR for neg/carry/overflow, AND for zero, with divide-by-zero override.
module alu_flag_reducer
  import tessia_alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             capture,
  input  logic             lane_dz,
  input  logic [FLG_W-1:0] lane_flags,
  output logic [FLG_W-1:0] flags
);

  logic [FLG_W-1:0] eff_flags;

  always_comb begin
    eff_flags = lane_dz ? FLAGS_DZ : lane_flags;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= FLAGS_INIT;
    end else if (init) begin
      flags <= FLAGS_INIT;
    end else if (capture) begin
      flags[FLG_NEG]   <= flags[FLG_NEG]   | eff_flags[FLG_NEG];
      flags[FLG_ZERO]  <= flags[FLG_ZERO]  & eff_flags[FLG_ZERO];
      flags[FLG_CARRY] <= flags[FLG_CARRY] | eff_flags[FLG_CARRY];
      flags[FLG_OVF]   <= flags[FLG_OVF]   | eff_flags[FLG_OVF];
    end
  end

endmodule

// File: rtl/alu_vector_sequencer.sv
// Execute-stage sequencer: streams one vector op through a shared scalar ALU, one lane per cycle.
module alu_vector_sequencer
  import tessia_alu_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned LANES = 4
)(
  input  logic                   clk,
  input  logic                   rst,
  alu_vector_sequencer_if.slave  bus
);

  localparam int unsigned IDX_W  = $clog2(LANES);
  localparam int unsigned REST_W = (LANES - 1) * N;

  seq_state_t        state;
  seq_state_t        state_next;
  logic [IDX_W-1:0]  idx;
  logic [REST_W-1:0] a_rest;
  logic [REST_W-1:0] b_rest;

  logic accept_c;
  logic capture_c;
  logic last_c;
  logic release_c;
  logic lane_dz_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    capture_c  = 1'b0;
    last_c     = 1'b0;
    release_c  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_valid && bus.start_ready) begin
          accept_c   = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        capture_c = 1'b1;
        if (idx == IDX_W'(LANES - 1)) begin
          last_c     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.done_valid && bus.done_ready) begin
          release_c  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The registered ALU operands always hold the lane currently being issued.
  always_comb begin
    lane_dz_c = is_div_op(bus.alu_ctrl) && (bus.alu_b == '0);
  end

  // Remaining lanes shift down into the ALU; results shift in from the top so lane 0 lands at the bottom.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx             <= '0;
      a_rest          <= '0;
      b_rest          <= '0;
      bus.alu_a       <= '0;
      bus.alu_b       <= '0;
      bus.alu_ctrl    <= '0;
      bus.start_ready <= 1'b1;
      bus.done_valid  <= 1'b0;
      bus.vec_result  <= '0;
      bus.div_zero    <= 1'b0;
    end else begin
      if (accept_c) begin
        idx             <= '0;
        a_rest          <= bus.vec_a[LANES*N-1:N];
        b_rest          <= bus.vec_b[LANES*N-1:N];
        bus.alu_a       <= bus.vec_a[N-1:0];
        bus.alu_b       <= bus.vec_b[N-1:0];
        bus.alu_ctrl    <= bus.op_ctrl;
        bus.start_ready <= 1'b0;
        bus.vec_result  <= '0;
        bus.div_zero    <= 1'b0;
      end
      if (capture_c) begin
        bus.vec_result <= {(lane_dz_c ? N'(0) : bus.alu_result), bus.vec_result[LANES*N-1:N]};
        if (lane_dz_c) bus.div_zero <= 1'b1;
        if (last_c) begin
          idx            <= '0;
          bus.alu_a      <= '0;
          bus.alu_b      <= '0;
          bus.alu_ctrl   <= '0;
          bus.done_valid <= 1'b1;
        end else begin
          idx       <= idx + IDX_W'(1);
          bus.alu_a <= a_rest[N-1:0];
          bus.alu_b <= b_rest[N-1:0];
          a_rest    <= a_rest >> N;
          b_rest    <= b_rest >> N;
        end
      end
      if (release_c) begin
        bus.done_valid  <= 1'b0;
        bus.start_ready <= 1'b1;
      end
    end
  end

  alu_flag_reducer u_flag_reducer (
    .clk        (clk),
    .rst        (rst),
    .init       (accept_c),
    .capture    (capture_c),
    .lane_dz    (lane_dz_c),
    .lane_flags (bus.alu_flags),
    .flags      (bus.vec_flags)
  );

endmodule

// File: tb/tb_alu_vector_sequencer.sv
// Directed bench for alu_vector_sequencer with a behavioural model of the shared ALU.
module tb_alu_vector_sequencer;
  import tessia_alu_pkg::*;

  localparam int unsigned N     = 8;
  localparam int unsigned LANES = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   lat;

  always #5 clk = ~clk;

  alu_vector_sequencer_if #(.N(N), .LANES(LANES)) bus ();

  alu_vector_sequencer #(.N(N), .LANES(LANES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Shared ALU model; divide/modulo by zero returns junk that the sequencer must discard.
  logic [N:0]     m_wide;
  logic [2*N-1:0] m_prod;
  logic [N-1:0]   m_res;
  logic           m_c;
  logic           m_v;
  logic           m_junk;

  always_comb begin
    m_wide = '0;
    m_prod = '0;
    m_res  = '0;
    m_c    = 1'b0;
    m_v    = 1'b0;
    m_junk = 1'b0;
    case (bus.alu_ctrl)
      ALU_ADD: begin
        m_wide = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        m_res  = m_wide[N-1:0];
        m_c    = m_wide[N];
        m_v    = (bus.alu_a[N-1] == bus.alu_b[N-1]) && (m_res[N-1] != bus.alu_a[N-1]);
      end
      ALU_SUB: begin
        m_res = bus.alu_a - bus.alu_b;
        m_c   = bus.alu_a < bus.alu_b;
        m_v   = (bus.alu_a[N-1] != bus.alu_b[N-1]) && (m_res[N-1] != bus.alu_a[N-1]);
      end
      ALU_MUL: begin
        m_prod = {{N{1'b0}}, bus.alu_a} * {{N{1'b0}}, bus.alu_b};
        m_res  = m_prod[N-1:0];
        m_c    = |m_prod[2*N-1:N];
      end
      ALU_OR:  m_res = bus.alu_a | bus.alu_b;
      ALU_AND: m_res = bus.alu_a & bus.alu_b;
      ALU_CPY: m_res = bus.alu_b;
      ALU_MOD: begin
        if (bus.alu_b == '0) begin m_res = 8'hEE; m_junk = 1'b1; end
        else m_res = bus.alu_a % bus.alu_b;
      end
      ALU_DIV: begin
        if (bus.alu_b == '0) begin m_res = 8'hEE; m_junk = 1'b1; end
        else m_res = bus.alu_a / bus.alu_b;
      end
      default: m_res = '0;
    endcase
    bus.alu_result = m_res;
    bus.alu_flags  = m_junk ? 4'b1011 : {m_res[N-1], (m_res == '0), m_c, m_v};
  end

  function automatic logic [31:0] vec4(input logic [7:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present an op, let it be accepted, then count cycles until done_valid (bounded).
  task automatic do_op(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                       output int cycles);
    int waits;
    bus.op_ctrl     = ctrl;
    bus.vec_a       = a;
    bus.vec_b       = b;
    bus.start_valid = 1'b1;
    waits = 0;
    while (!bus.start_ready && waits < 20) begin tick(); waits++; end
    tick();
    bus.start_valid = 1'b0;
    bus.vec_a       = 32'hDEAD_BEEF;
    bus.vec_b       = 32'h5A5A_5A5A;
    bus.op_ctrl     = ALU_MUL;
    cycles = 0;
    while (!bus.done_valid && cycles < 20) begin tick(); cycles++; end
  endtask

  initial begin
    rst             = 1'b1;
    bus.start_valid = 1'b0;
    bus.op_ctrl     = '0;
    bus.vec_a       = '0;
    bus.vec_b       = '0;
    bus.done_ready  = 1'b1;
    tick();
    tick();
    check("rst_start_ready", 32'(bus.start_ready), 32'd1);
    check("rst_done_valid",  32'(bus.done_valid),  32'd0);
    check("rst_vec_result",  bus.vec_result,       32'd0);
    check("rst_vec_flags",   32'(bus.vec_flags),   32'h4);
    check("rst_div_zero",    32'(bus.div_zero),    32'd0);
    check("rst_alu_bus",     {bus.alu_ctrl, bus.alu_b, bus.alu_a}, 32'd0);
    rst = 1'b0;
    tick();

    // ADD, plain case and latency
    do_op(ALU_ADD, vec4(1, 2, 3, 4), vec4(10, 20, 30, 40), lat);
    check("add_latency",     32'(lat),             32'd4);
    check("add_result",      bus.vec_result,       vec4(11, 22, 33, 44));
    check("add_flags",       32'(bus.vec_flags),   32'h0);
    check("add_div_zero",    32'(bus.div_zero),    32'd0);
    check("add_start_ready", 32'(bus.start_ready), 32'd0);
    check("add_alu_idle",    {bus.alu_ctrl, bus.alu_b, bus.alu_a}, 32'd0);
    tick();
    check("add_release_dv",  32'(bus.done_valid),  32'd0);
    check("add_release_sr",  32'(bus.start_ready), 32'd1);
    check("add_result_hold", bus.vec_result,       vec4(11, 22, 33, 44));

    // SUB with backpressure; a competing start during DONE must be ignored
    bus.done_ready = 1'b0;
    do_op(ALU_SUB, vec4(5, 0, 7, 7), vec4(5, 1, 2, 7), lat);
    check("sub_latency", 32'(lat), 32'd4);
    bus.start_valid = 1'b1;
    bus.op_ctrl     = ALU_ADD;
    bus.vec_a       = vec4(9, 9, 9, 9);
    bus.vec_b       = vec4(9, 9, 9, 9);
    for (int i = 0; i < 5; i++) begin
      check("bp_done_valid",  32'(bus.done_valid),  32'd1);
      check("bp_start_ready", 32'(bus.start_ready), 32'd0);
      check("bp_result",      bus.vec_result,       vec4(0, 8'hFF, 5, 0));
      check("bp_flags",       32'(bus.vec_flags),   32'hA);
      tick();
    end
    bus.done_ready = 1'b1;
    tick();
    check("bp_release_dv", 32'(bus.done_valid),  32'd0);
    check("bp_release_sr", 32'(bus.start_ready), 32'd1);
    bus.start_valid = 1'b0;
    tick();
    check("bp_no_overlap", 32'(bus.start_ready), 32'd1);

    // DIV with zero divisors on lanes 1 and 3
    do_op(ALU_DIV, vec4(8, 9, 6, 1), vec4(2, 0, 3, 0), lat);
    check("div_result",   bus.vec_result,     vec4(4, 0, 2, 0));
    check("div_flags",    32'(bus.vec_flags), 32'h0);
    check("div_div_zero", 32'(bus.div_zero),  32'd1);
    tick();

    // Modulo op without zero divisors clears div_zero
    do_op(ALU_MOD, vec4(7, 9, 10, 200), vec4(3, 4, 10, 7), lat);
    check("mod_result",   bus.vec_result,     vec4(1, 1, 0, 4));
    check("mod_flags",    32'(bus.vec_flags), 32'h0);
    check("mod_div_zero", 32'(bus.div_zero),  32'd0);
    tick();

    // Unknown opcode yields zero lanes, no error
    do_op(4'hA, vec4(1, 2, 3, 4), vec4(0, 0, 0, 0), lat);
    check("unk_result",   bus.vec_result,     32'd0);
    check("unk_flags",    32'(bus.vec_flags), 32'h4);
    check("unk_div_zero", 32'(bus.div_zero),  32'd0);
    tick();

    // Reset while issuing lane 2
    bus.op_ctrl     = ALU_ADD;
    bus.vec_a       = vec4(5, 6, 7, 8);
    bus.vec_b       = vec4(1, 1, 1, 1);
    bus.start_valid = 1'b1;
    tick();
    bus.start_valid = 1'b0;
    tick();
    tick();
    check("mid_alu_a", 32'(bus.alu_a), 32'd7);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_done_valid",  32'(bus.done_valid),  32'd0);
    check("mid_rst_start_ready", 32'(bus.start_ready), 32'd1);
    check("mid_rst_vec_result",  bus.vec_result,       32'd0);
    check("mid_rst_vec_flags",   32'(bus.vec_flags),   32'h4);
    check("mid_rst_alu_bus",     {bus.alu_ctrl, bus.alu_b, bus.alu_a}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // ADD after reset exercising carry, overflow and zero lanes
    do_op(ALU_ADD, vec4(100, 200, 127, 0), vec4(100, 100, 1, 0), lat);
    check("post_latency", 32'(lat),           32'd4);
    check("post_result",  bus.vec_result,     vec4(200, 44, 128, 0));
    check("post_flags",   32'(bus.vec_flags), 32'hB);
    tick();

    // CPY of all-zero B: every lane zero
    do_op(ALU_CPY, vec4(3, 4, 5, 6), vec4(0, 0, 0, 0), lat);
    check("cpy_result", bus.vec_result,     32'd0);
    check("cpy_flags",  32'(bus.vec_flags), 32'h4);
    tick();

    // AND with a single nonzero lane clears zero
    do_op(ALU_AND, vec4(8'hFF, 8'h0F, 8'h00, 8'hF0), vec4(0, 0, 0, 8'h3C), lat);
    check("and_result", bus.vec_result,     vec4(0, 0, 0, 8'h30));
    check("and_flags",  32'(bus.vec_flags), 32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_vector_sequencer.md
Name: alu_vector_sequencer

Overview:
- Runs one vector operation of LANES elements through a single shared combinational ALU (N-bit, 4-bit ctrl, flags {neg, zero, carry, overflow}), one element per cycle.
- Latches the operands on a start handshake and issues the elements to the ALU.
- Collects the results into a vector, reduces the per-lane flags, and suppresses divide-by-zero lanes.
- Sits in the Execute stage between decode/register-read and the writeback register.

Parameters:
- N, 8, element width in bits; must match the shared ALU.
- LANES, 4, elements per vector; must be at least 2.
- IDX_W, $clog2(LANES), width of the lane counter; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_valid  in  1  a vector op is presented
- start_ready  out  1  sequencer can accept an op
- op_ctrl  in  4  ALU opcode, same encoding as the ALU ctrl
- vec_a  in  LANES*N  operand A; lane i occupies bits [i*N +: N]
- vec_b  in  LANES*N  operand B; same packing
- alu_a  out  N  to the shared ALU, input a
- alu_b  out  N  to the shared ALU, input b
- alu_ctrl  out  4  to the shared ALU, ctrl
- alu_result  in  N  from the shared ALU, combinational result
- alu_flags  in  4  from the shared ALU, {neg, zero, carry, overflow}
- done_valid  out  1  result vector is available
- done_ready  in  1  consumer accepts the result
- vec_result  out  LANES*N  result vector, same packing as the operands
- vec_flags  out  4  reduced flags {neg, zero, carry, overflow}
- div_zero  out  1  at least one lane of a % or / op had b == 0

Behaviour:
- States: IDLE, ISSUE, DONE.
- Reset (asynchronous, any state): state = IDLE and lane counter = 0; an operation in flight is dropped silently.
  - Reset values: start_ready = 1, done_valid = 0, vec_result = 0, vec_flags = 4'b0100, div_zero = 0.
  - alu_a, alu_b and alu_ctrl = 0.
- IDLE:
  - start_ready = 1.
  - On the edge where start_valid && start_ready: latch op_ctrl, vec_a, vec_b; clear the result vector, div_zero and the flag accumulators; go to ISSUE with idx = 0.
- ISSUE (start_ready = 0):
  - Drive alu_a = A[idx], alu_b = B[idx], alu_ctrl = latched ctrl.
  - At each edge, capture lane idx from alu_result and alu_flags, then increment idx.
  - After the capture at idx = LANES-1, go to DONE.
- ISSUE timing:
  - Exactly LANES cycles in ISSUE.
  - done_valid rises LANES cycles after the accept edge.
  - The ALU is driven only in ISSUE; in other states alu_a, alu_b and alu_ctrl = 0.
- Divide by zero:
  - Applies when ctrl is 4'b0100 (%) or 4'b0111 (/) and B[idx] == 0.
  - The lane result is forced to 0, the ALU result is ignored, and the lane's flags are taken as {0, 1, 0, 0}.
  - div_zero is set and stays set for the rest of the op.
- Flag reduction over all lanes:
  - neg = OR of the lane neg flags.
  - zero = AND of the lane zero flags.
  - carry = OR of the lane carry flags.
  - overflow = OR of the lane overflow flags.
- Unknown ctrl (4'b1000 to 4'b1111): passed to the ALU unchanged; the ALU returns 0 per lane. No error is signalled.
- DONE:
  - done_valid = 1; vec_result, vec_flags and div_zero stay stable until the handshake.
  - On done_valid && done_ready, go to IDLE.
  - The outputs keep their last values until the next accept; done_valid = 0 in IDLE.
- No overlap: a new op is never accepted in the DONE handshake cycle; start_ready rises only once back in IDLE.
- start_valid while busy is ignored, and the inputs need not be held after the accept edge.

Decomposition:
- Shared package (tessia_alu_pkg):
  - Opcode constants: ALU_ADD=0000, ALU_SUB=0001, ALU_MUL=0010, ALU_OR=0011, ALU_MOD=0100, ALU_AND=0101, ALU_CPY=0110, ALU_DIV=0111.
  - Flag bit index constants: FLG_NEG=3, FLG_ZERO=2, FLG_CARRY=1, FLG_OVF=0.
  - State enum seq_state_t {IDLE, ISSUE, DONE}.
- One natural sub-module: alu_flag_reducer. It holds the per-lane flag accumulation, applies the reset and init values, and applies the divide-by-zero override.
- The ALU itself is instantiated by the parent, not inside this block.

Test Plan:
- ADD, N=8, LANES=4: A={1,2,3,4}, B={10,20,30,40} -> result {11,22,33,44}; flags 0000; done_valid 4 cycles after the accept edge.
- SUB: A={5,0,7,7}, B={5,1,2,7} -> result {0,-1,5,0}; neg=1, zero=0.
- DIV: A={8,9,6,1}, B={2,0,3,0} -> result {4,0,2,0}; div_zero=1; ALU output on lanes 1 and 3 ignored.
- Backpressure: done_ready held 0 for 5 cycles after done_valid -> outputs stable and start_ready=0 throughout. Then done_ready=1 -> IDLE next cycle; start_ready=1.
- Reset mid-op: assert rst during ISSUE at idx=2 -> immediately state IDLE, done_valid=0, vec_result=0, vec_flags=0100, alu_* = 0. A following ADD completes correctly.
- CPY with all B=0: zero flag=1 (all lanes zero). Then AND with one nonzero lane -> zero flag=0.
